// File: rtl/uc_irq_if.sv
// Signal bundle between the uc_irq control unit and the 8-bit datapath.
// The datapath side drives opcode/z/irq; the control unit drives every strobe.
interface uc_irq_if;
    logic [5:0] opcode;
    logic       z;
    logic       irq;
    logic       s_inc;
    logic       s_inm;
    logic       we3;
    logic       wez;
    logic [2:0] op_alu;
    logic       push;
    logic       pop;
    logic       s_pop;
    logic       write_enable;
    logic       s_load;
    logic       we_es;
    logic       s_cargaes;
    logic       s_interrupcion;
    logic       irq_ack;
    logic       in_isr;
    logic       stack_err;

    modport master (
        output opcode, z, irq,
        input  s_inc, s_inm, we3, wez, op_alu, push, pop, s_pop, write_enable,
               s_load, we_es, s_cargaes, s_interrupcion, irq_ack, in_isr, stack_err
    );

    modport slave (
        input  opcode, z, irq,
        output s_inc, s_inm, we3, wez, op_alu, push, pop, s_pop, write_enable,
               s_load, we_es, s_cargaes, s_interrupcion, irq_ack, in_isr, stack_err
    );
endinterface

// File: rtl/uc_irq.sv
// Control unit for the 8-bit CPU datapath: combinational opcode decode plus
// interrupt sequencing (edge detect, pending, vector injection) and stack depth tracking.
module uc_irq #(
    parameter int STACK_DEPTH = 16
) (
    input  logic     clk,
    input  logic     reset,
    uc_irq_if.slave  cu
);
    localparam int DW = $clog2(STACK_DEPTH + 1);
    localparam logic [DW-1:0] DEPTH_MAX = DW'(STACK_DEPTH);
    localparam logic [DW-1:0] DEPTH_ONE = DW'(1);

    logic          irq_q, irq_d;
    logic          pending_q, pending_d;
    logic          ie_q, ie_d;
    logic          in_isr_q, in_isr_d;
    logic [DW-1:0] depth_q, depth_d;
    logic          stack_err_q, stack_err_d;

    logic          take;
    logic          dec_s_inc, dec_s_inm, dec_we3, dec_wez;
    logic          dec_push, dec_pop, dec_write_enable, dec_s_load;
    logic          dec_we_es, dec_s_cargaes, dec_s_interrupcion, dec_irq_ack;

    always_comb begin
        dec_s_inc          = 1'b1;
        dec_s_inm          = 1'b0;
        dec_we3            = 1'b0;
        dec_wez            = 1'b0;
        dec_push           = 1'b0;
        dec_pop            = 1'b0;
        dec_write_enable   = 1'b0;
        dec_s_load         = 1'b0;
        dec_we_es          = 1'b0;
        dec_s_cargaes      = 1'b0;
        dec_s_interrupcion = 1'b0;
        dec_irq_ack        = 1'b0;

        irq_d       = cu.irq;
        ie_d        = ie_q;
        in_isr_d    = in_isr_q;
        depth_d     = depth_q;
        stack_err_d = stack_err_q;

        take      = pending_q & ie_q & (depth_q < DEPTH_MAX);
        // A fresh edge arriving in the take cycle belongs to a new request and stays pending.
        pending_d = (pending_q & ~take) | (cu.irq & ~irq_q);

        if (take) begin
            // The current instruction is squashed; its PC is pushed so it re-runs after RETI.
            dec_push           = 1'b1;
            dec_s_interrupcion = 1'b1;
            dec_irq_ack        = 1'b1;
            ie_d               = 1'b0;
            in_isr_d           = 1'b1;
            depth_d            = depth_q + DEPTH_ONE;
        end else begin
            casez (cu.opcode)
                6'b0?????: begin dec_we3 = 1'b1; dec_wez = 1'b1; end
                6'b1000??: begin dec_s_inm = 1'b1; dec_we3 = 1'b1; end
                6'b1001??: begin dec_s_load = 1'b1; dec_we3 = 1'b1; end
                6'b1010??: dec_write_enable = 1'b1;
                6'b1011??: begin dec_s_cargaes = 1'b1; dec_we3 = 1'b1; end
                6'b1100??: dec_we_es = 1'b1;
                6'b110100: dec_s_inc = 1'b0;
                6'b110101: dec_s_inc = ~cu.z;
                6'b110110: dec_s_inc = cu.z;
                6'b110111: begin
                    if (depth_q == DEPTH_MAX) begin
                        stack_err_d = 1'b1;
                    end else begin
                        dec_push  = 1'b1;
                        dec_s_inc = 1'b0;
                        depth_d   = depth_q + DEPTH_ONE;
                    end
                end
                6'b111000, 6'b111001: begin
                    if (depth_q == '0) begin
                        stack_err_d = 1'b1;
                    end else begin
                        dec_pop = 1'b1;
                        depth_d = depth_q - DEPTH_ONE;
                    end
                    if (cu.opcode[0]) begin
                        ie_d     = 1'b1;
                        in_isr_d = 1'b0;
                    end
                end
                6'b111010: ie_d = 1'b1;
                6'b111011: ie_d = 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q       <= 1'b0;
            pending_q   <= 1'b0;
            ie_q        <= 1'b0;
            in_isr_q    <= 1'b0;
            depth_q     <= '0;
            stack_err_q <= 1'b0;
        end else begin
            irq_q       <= irq_d;
            pending_q   <= pending_d;
            ie_q        <= ie_d;
            in_isr_q    <= in_isr_d;
            depth_q     <= depth_d;
            stack_err_q <= stack_err_d;
        end
    end

    // Reset holds the datapath in a harmless fetch: PC+1, nothing written.
    assign cu.s_inc          = dec_s_inc | reset;
    assign cu.s_inm          = dec_s_inm & ~reset;
    assign cu.we3            = dec_we3 & ~reset;
    assign cu.wez            = dec_wez & ~reset;
    assign cu.op_alu         = reset ? 3'b000 : cu.opcode[4:2];
    assign cu.push           = dec_push & ~reset;
    assign cu.pop            = dec_pop & ~reset;
    assign cu.s_pop          = dec_pop & ~reset;
    assign cu.write_enable   = dec_write_enable & ~reset;
    assign cu.s_load         = dec_s_load & ~reset;
    assign cu.we_es          = dec_we_es & ~reset;
    assign cu.s_cargaes      = dec_s_cargaes & ~reset;
    assign cu.s_interrupcion = dec_s_interrupcion & ~reset;
    assign cu.irq_ack        = dec_irq_ack & ~reset;
    assign cu.in_isr         = in_isr_q & ~reset;
    assign cu.stack_err      = stack_err_q & ~reset;
endmodule

// File: tb/tb_uc_irq.sv
// Directed bench for uc_irq: decode, interrupt take/return and stack depth limits.
module tb_uc_irq;
    localparam logic [5:0] OP_ALU  = 6'b000100;
    localparam logic [5:0] OP_LI   = 6'b100000;
    localparam logic [5:0] OP_LD   = 6'b100100;
    localparam logic [5:0] OP_ST   = 6'b101000;
    localparam logic [5:0] OP_IN   = 6'b101100;
    localparam logic [5:0] OP_OUT  = 6'b110000;
    localparam logic [5:0] OP_J    = 6'b110100;
    localparam logic [5:0] OP_JZ   = 6'b110101;
    localparam logic [5:0] OP_JNZ  = 6'b110110;
    localparam logic [5:0] OP_CALL = 6'b110111;
    localparam logic [5:0] OP_RET  = 6'b111000;
    localparam logic [5:0] OP_RETI = 6'b111001;
    localparam logic [5:0] OP_EI   = 6'b111010;
    localparam logic [5:0] OP_DI   = 6'b111011;
    localparam logic [5:0] OP_NOP  = 6'b111100;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    uc_irq_if cu_if ();

    uc_irq #(.STACK_DEPTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .cu    (cu_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are checked 1ns later.
    task automatic step(input logic rst, input logic [5:0] op, input logic zz, input logic ii);
        @(negedge clk);
        reset        = rst;
        cu_if.opcode = op;
        cu_if.z      = zz;
        cu_if.irq    = ii;
        #1;
    endtask

    initial begin
        cu_if.opcode = OP_ALU;
        cu_if.z      = 1'b0;
        cu_if.irq    = 1'b0;

        // Reset held two cycles with an ALU opcode on the bus.
        for (int i = 0; i < 2; i++) begin
            step(1'b1, OP_ALU, 1'b0, 1'b0);
            chk("rst_s_inc", cu_if.s_inc, 1);
            chk("rst_we3", cu_if.we3, 0);
            chk("rst_push", cu_if.push, 0);
            chk("rst_op_alu", cu_if.op_alu, 0);
        end
        step(1'b0, OP_ALU, 1'b0, 1'b0);
        chk("alu_we3", cu_if.we3, 1);
        chk("alu_wez", cu_if.wez, 1);
        chk("alu_op_alu", cu_if.op_alu, 8'h1);
        chk("alu_in_isr", cu_if.in_isr, 0);

        // Plain decode.
        step(1'b0, OP_LI, 1'b0, 1'b0);
        chk("li_s_inm", cu_if.s_inm, 1);
        chk("li_wez", cu_if.wez, 0);
        step(1'b0, OP_LD, 1'b0, 1'b0);
        chk("ld_s_load", cu_if.s_load, 1);
        step(1'b0, OP_ST, 1'b0, 1'b0);
        chk("st_we", cu_if.write_enable, 1);
        chk("st_we3", cu_if.we3, 0);
        step(1'b0, OP_IN, 1'b0, 1'b0);
        chk("in_cargaes", cu_if.s_cargaes, 1);
        step(1'b0, OP_OUT, 1'b0, 1'b0);
        chk("out_we_es", cu_if.we_es, 1);
        step(1'b0, OP_J, 1'b0, 1'b0);
        chk("j_s_inc", cu_if.s_inc, 0);
        step(1'b0, OP_JZ, 1'b1, 1'b0);
        chk("jz_z1", cu_if.s_inc, 0);
        step(1'b0, OP_JZ, 1'b0, 1'b0);
        chk("jz_z0", cu_if.s_inc, 1);
        step(1'b0, OP_JNZ, 1'b1, 1'b0);
        chk("jnz_z1", cu_if.s_inc, 1);
        step(1'b0, OP_JNZ, 1'b0, 1'b0);
        chk("jnz_z0", cu_if.s_inc, 0);

        // irq with interrupts disabled is held pending; DI keeps it off, EI lets it in next cycle.
        step(1'b0, OP_NOP, 1'b0, 1'b1);
        chk("ie0_ack_a", cu_if.irq_ack, 0);
        step(1'b0, OP_NOP, 1'b0, 1'b0);
        chk("ie0_ack_b", cu_if.irq_ack, 0);
        step(1'b0, OP_DI, 1'b0, 1'b0);
        chk("di_ack", cu_if.irq_ack, 0);
        step(1'b0, OP_EI, 1'b0, 1'b0);
        chk("ei_ack", cu_if.irq_ack, 0);
        step(1'b0, OP_ALU, 1'b0, 1'b0);
        chk("take1_ack", cu_if.irq_ack, 1);
        chk("take1_push", cu_if.push, 1);
        chk("take1_vec", cu_if.s_interrupcion, 1);
        chk("take1_we3", cu_if.we3, 0);
        chk("take1_wez", cu_if.wez, 0);
        step(1'b0, OP_NOP, 1'b0, 1'b0);
        chk("isr1_in_isr", cu_if.in_isr, 1);
        chk("isr1_ack", cu_if.irq_ack, 0);

        // Second edge inside the ISR is taken one cycle after RETI.
        step(1'b0, OP_NOP, 1'b0, 1'b1);
        chk("isr_edge_ack", cu_if.irq_ack, 0);
        step(1'b0, OP_RETI, 1'b0, 1'b0);
        chk("reti_pop", cu_if.pop, 1);
        chk("reti_s_pop", cu_if.s_pop, 1);
        chk("reti_ack", cu_if.irq_ack, 0);
        step(1'b0, OP_ALU, 1'b0, 1'b0);
        chk("take2_in_isr", cu_if.in_isr, 0);
        chk("take2_ack", cu_if.irq_ack, 1);
        chk("take2_push", cu_if.push, 1);
        step(1'b0, OP_RETI, 1'b0, 1'b0);
        chk("reti2_pop", cu_if.pop, 1);
        step(1'b0, OP_NOP, 1'b0, 1'b0);
        chk("post_reti_isr", cu_if.in_isr, 0);
        chk("post_reti_ack", cu_if.irq_ack, 0);

        // Interrupts enabled: edge -> pending -> take on the following cycle.
        step(1'b0, OP_NOP, 1'b0, 1'b1);
        chk("ie1_edge_ack", cu_if.irq_ack, 0);
        step(1'b0, OP_ALU, 1'b0, 1'b0);
        chk("take3_ack", cu_if.irq_ack, 1);
        chk("take3_we3", cu_if.we3, 0);
        step(1'b0, OP_RETI, 1'b0, 1'b0);
        chk("reti3_pop", cu_if.pop, 1);
        step(1'b0, OP_DI, 1'b0, 1'b0);
        chk("di2_ack", cu_if.irq_ack, 0);

        // Fill the stack, then overflow.
        for (int i = 0; i < 16; i++) begin
            step(1'b0, OP_CALL, 1'b0, 1'b0);
            chk($sformatf("call%0d_push", i), cu_if.push, 1);
            chk($sformatf("call%0d_s_inc", i), cu_if.s_inc, 0);
        end
        step(1'b0, OP_CALL, 1'b0, 1'b0);
        chk("call_ovf_push", cu_if.push, 0);
        chk("call_ovf_s_inc", cu_if.s_inc, 1);
        chk("call_ovf_err_pre", cu_if.stack_err, 0);
        step(1'b0, OP_NOP, 1'b0, 1'b0);
        chk("ovf_err", cu_if.stack_err, 1);

        // Full stack blocks the take until one entry is popped.
        step(1'b0, OP_EI, 1'b0, 1'b0);
        step(1'b0, OP_NOP, 1'b0, 1'b1);
        chk("full_edge_ack", cu_if.irq_ack, 0);
        step(1'b0, OP_NOP, 1'b0, 1'b0);
        chk("full_block_ack", cu_if.irq_ack, 0);
        chk("full_block_push", cu_if.push, 0);
        step(1'b0, OP_RET, 1'b0, 1'b0);
        chk("full_ret_ack", cu_if.irq_ack, 0);
        chk("full_ret_pop", cu_if.pop, 1);
        step(1'b0, OP_NOP, 1'b0, 1'b0);
        chk("held_take_ack", cu_if.irq_ack, 1);
        chk("held_take_push", cu_if.push, 1);
        step(1'b0, OP_NOP, 1'b0, 1'b0);
        chk("held_in_isr", cu_if.in_isr, 1);

        // Drain the stack, then underflow with RET and RETI.
        for (int i = 0; i < 16; i++) begin
            step(1'b0, OP_RET, 1'b0, 1'b0);
            chk($sformatf("ret%0d_pop", i), cu_if.pop, 1);
        end
        step(1'b0, OP_RET, 1'b0, 1'b0);
        chk("ret_udf_pop", cu_if.pop, 0);
        chk("ret_udf_s_pop", cu_if.s_pop, 0);
        chk("ret_udf_s_inc", cu_if.s_inc, 1);
        step(1'b0, OP_RETI, 1'b0, 1'b0);
        chk("reti_udf_pop", cu_if.pop, 0);
        chk("reti_udf_in_isr", cu_if.in_isr, 1);
        step(1'b0, OP_NOP, 1'b0, 1'b0);
        chk("reti_udf_clr", cu_if.in_isr, 0);
        chk("udf_err", cu_if.stack_err, 1);

        // Reset clears the sticky error.
        step(1'b1, OP_CALL, 1'b0, 1'b0);
        chk("rst2_err", cu_if.stack_err, 0);
        chk("rst2_s_inc", cu_if.s_inc, 1);
        chk("rst2_push", cu_if.push, 0);
        step(1'b0, OP_NOP, 1'b0, 1'b0);
        chk("rst2_err_after", cu_if.stack_err, 0);
        chk("rst2_in_isr", cu_if.in_isr, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
